// File: rtl/rr_merge_pkg.sv
// Shared definitions for the 4:1 round-robin stream merge.
// Channel count, channel index type and a one-hot decode helper.
package rr_merge_pkg;

    localparam int N_CH = 4;

    typedef logic [1:0] ch_idx_t;

    function automatic logic [N_CH-1:0] idx_onehot(input ch_idx_t idx);
        logic [N_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arb_4.sv
// Combinational 4-way round-robin arbiter.
// Grants the first requester found searching upward from ptr, wrapping 3->0.
module rr_arb_4
    import rr_merge_pkg::*;
(
    input  logic [3:0] req,
    input  ch_idx_t    ptr,
    output logic       gnt_vld,
    output ch_idx_t    gnt_idx
);

    ch_idx_t cand;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        cand    = ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = ptr + ch_idx_t'(k);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_merge_4_1.sv
// Merges four valid/ready streams into one registered output stream.
// Round-robin fairness; full throughput when the consumer is always ready.
module rr_merge_4_1
    import rr_merge_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    ch_idx_t          ptr;
    ch_idx_t          gnt_idx;
    logic             gnt_vld;
    logic             can_accept;
    logic             in_xfer;
    logic [WIDTH-1:0] gnt_data;

    assign can_accept = !out_valid || out_ready;

    rr_arb_4 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Gating with rst_n keeps every ready low while reset is held.
    assign in_xfer  = rst_n && gnt_vld && can_accept;
    assign in_ready = in_xfer ? idx_onehot(gnt_idx) : 4'b0000;

    assign gnt_data = (gnt_idx == 2'd0) ? d0 :
                      (gnt_idx == 2'd1) ? d1 :
                      (gnt_idx == 2'd2) ? d2 : d3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
            ptr       <= gnt_idx + 2'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_merge_4_1.sv
// Scoreboard bench for rr_merge_4_1: a reference model predicts grants and
// queues expected words; a separate monitor checks words as the DUT presents them.
module tb_rr_merge_4_1;

    localparam int W = 4;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } word_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;

    int    checks;
    int    errors;
    word_t q[$];
    int    m_ptr;
    logic  m_valid;

    rr_merge_4_1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] chan_data(input int c);
        case (c)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    // Reference model: evaluated mid-cycle on the inputs for the coming edge.
    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        logic       can;
        int         g;
        int         c;
        exp_rdy = 4'b0000;
        g       = -1;
        can     = !m_valid || out_ready;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (g < 0 && in_valid[c]) g = c;
            end
            if (g >= 0 && can) exp_rdy[g] = 1'b1;
        end
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
        end
        if (!rst_n) begin
            q.delete();
            m_ptr   = 0;
            m_valid = 1'b0;
        end else if (g >= 0 && can) begin
            q.push_back(word_t'{sel: g[1:0], data: chan_data(g)});
            m_ptr   = (g + 1) % 4;
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Monitor: checks the presented word against the scoreboard head.
    always @(posedge clk) begin
        #2;
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, m_valid);
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word t=%0t got sel %0d data %h want none", $time, out_sel, out_data);
            end else begin
                if (out_data !== q[0].data || out_sel !== q[0].sel) begin
                    errors++;
                    $display("FAIL out_word t=%0t got sel %0d data %h want sel %0d data %h",
                             $time, out_sel, out_data, q[0].sel, q[0].data);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic [3:0] v, input logic ordy,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] e);
        @(posedge clk);
        #1;
        rst_n     = rn;
        in_valid  = v;
        out_ready = ordy;
        d0 = a; d1 = b; d2 = c; d3 = e;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_ptr     = 0;
        m_valid   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;

        // Reset held with all channels requesting
        drive(1'b0, 4'hF, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        drive(1'b0, 4'hF, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        #2;
        chk("rst_in_ready", {4'h0, in_ready}, 8'h00);
        chk("rst_out_valid", {7'h0, out_valid}, 8'h00);
        chk("rst_out_data", {4'h0, out_data}, 8'h00);
        chk("rst_out_sel", {6'h0, out_sel}, 8'h00);

        // Full-rate round robin: words 1,2,3,4,1,2,3,4 from channels 0..3
        for (int i = 0; i <= 8; i++) begin
            drive(1'b1, (i < 8) ? 4'hF : 4'h0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
            #2;
            if (i == 0) chk("first_grant_ch0", {4'h0, in_ready}, 8'h01);
            if (i >= 1) begin
                chk("rr_out_sel", {6'h0, out_sel}, 8'((i - 1) % 4));
                chk("rr_out_data", {4'h0, out_data}, 8'(((i - 1) % 4) + 1));
            end
        end

        // Lone channel 2, then lone channel 3 granted next
        drive(1'b1, 4'b0100, 1'b1, 4'h0, 4'h0, 4'hA, 4'h0);
        #2;
        chk("ch2_in_ready", {4'h0, in_ready}, 8'h04);
        drive(1'b1, 4'b1000, 1'b1, 4'h0, 4'h0, 4'h0, 4'hB);
        #2;
        chk("ch2_out_valid", {7'h0, out_valid}, 8'h01);
        chk("ch2_out_data", {4'h0, out_data}, 8'h0A);
        chk("ch2_out_sel", {6'h0, out_sel}, 8'h02);
        chk("ch3_next_in_ready", {4'h0, in_ready}, 8'h08);

        // Park ptr at 3, then 4'b0011 must wrap to channel 0, then channel 1
        drive(1'b1, 4'b0100, 1'b1, 4'h0, 4'h0, 4'h6, 4'h0);
        drive(1'b1, 4'b0011, 1'b1, 4'h5, 4'h7, 4'h0, 4'h0);
        #2;
        chk("wrap_in_ready", {4'h0, in_ready}, 8'h01);
        drive(1'b1, 4'b0011, 1'b1, 4'h5, 4'h7, 4'h0, 4'h0);
        #2;
        chk("after_wrap_in_ready", {4'h0, in_ready}, 8'h02);

        // Stall with all channels requesting: word from ch2 must hold
        drive(1'b1, 4'hF, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hF, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
            #2;
            chk("stall_in_ready", {4'h0, in_ready}, 8'h00);
            chk("stall_out_data", {4'h0, out_data}, 8'h03);
            chk("stall_out_sel", {6'h0, out_sel}, 8'h02);
        end
        drive(1'b1, 4'hF, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        #2;
        chk("refill_in_ready", {4'h0, in_ready}, 8'h08);
        drive(1'b1, 4'hF, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        #2;
        chk("refill_out_data", {4'h0, out_data}, 8'h04);

        // Reset while stalled discards the word; first grant afterwards is ch0
        drive(1'b0, 4'hF, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        #2;
        chk("rst_stall_in_ready", {4'h0, in_ready}, 8'h00);
        drive(1'b1, 4'hF, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        #2;
        chk("rst_stall_out_valid", {7'h0, out_valid}, 8'h00);
        chk("rst_stall_grant", {4'h0, in_ready}, 8'h01);

        // Randomised traffic with occasional backpressure and resets
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 79) != 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        for (int i = 0; i < 4; i++) drive(1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #3;
        chk("drain_queue_empty", 8'(q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
